// File: rtl/rst_seq_pkg.sv
// rst_pkg: shared defaults, channel names and lowest-set-bit helper for the reset sequencer
package rst_pkg;
   localparam int RST_N_CH_DEF    = 3;
   localparam int RST_STRETCH_DEF = 4;
   typedef enum int {
      RST_CH_CORE = 0,
      RST_CH_MEM  = 1,
      RST_CH_IO   = 2
   } rst_ch_e;
   // Returns 16 when no bit is set, which never lowers a release index.
   function automatic logic [4:0] rst_low_bit(input logic [15:0] v);
      rst_low_bit = 5'd16;
      for (int i = 15; i >= 0; i--)
         if (v[i]) rst_low_bit = 5'(i);
   endfunction
endpackage

// File: rtl/rst_stretch_cnt.sv
// rst_stretch_cnt: modulo-STRETCH counter with restart, tick on terminal count
module rst_stretch_cnt #(
   parameter int STRETCH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int W = (STRETCH > 1) ? $clog2(STRETCH) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      tick  = en && (cnt_q == W'(STRETCH - 1));
      cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/rst_seq.sv
// rst_seq: staged release of N_CH active-low resets with per-channel re-request
module rst_seq
   import rst_pkg::*;
#(
   parameter int N_CH         = RST_N_CH_DEF,
   parameter int STRETCH      = RST_STRETCH_DEF,
   parameter bit ARM_REQUIRED = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] usr_rst,
   output logic [N_CH-1:0] rstn,
   output logic            armed,
   output logic            done,
   output logic [N_CH-1:0] cause
);
   localparam int IW = $clog2(N_CH + 1);
   logic            armed_q, armed_d, done_q, done_d;
   logic [IW-1:0]   rel_idx_q, rel_idx_d, req_idx, rel_idx_nx;
   logic [N_CH-1:0] rstn_q, rstn_d, cause_q, cause_d;
   logic [4:0]      low;
   logic            arming, req, cnt_en, tick;
   function automatic logic [N_CH-1:0] thermo(input logic [IW-1:0] idx);
      thermo = '0;
      for (int i = 0; i < N_CH; i++) thermo[i] = (i < int'(idx));
   endfunction
   rst_stretch_cnt #(.STRETCH(STRETCH)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (req),
      .en   (cnt_en),
      .tick (tick)
   );
   always_comb begin
      low        = rst_low_bit(16'(usr_rst));
      arming     = !armed_q && (ARM_REQUIRED ? |usr_rst : 1'b1);
      req        = (armed_q && |usr_rst) || arming;
      cnt_en     = armed_q && usr_rst == '0 && rel_idx_q < IW'(N_CH);
      req_idx    = (low < 5'(rel_idx_q)) ? IW'(low) : rel_idx_q;
      rel_idx_nx = rel_idx_q + 1'b1;
   end
   always_comb begin
      armed_d   = armed_q;
      rel_idx_d = rel_idx_q;
      rstn_d    = rstn_q;
      done_d    = done_q;
      cause_d   = cause_q;
      if (req) begin
         // A finished episode's cause is kept until the next request starts a new one.
         armed_d   = 1'b1;
         rel_idx_d = req_idx;
         rstn_d    = thermo(req_idx);
         done_d    = 1'b0;
         cause_d   = (done_q ? '0 : cause_q) | usr_rst;
      end else if (tick) begin
         rel_idx_d = rel_idx_nx;
         rstn_d    = thermo(rel_idx_nx);
         done_d    = rel_idx_nx == IW'(N_CH);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         armed_q   <= 1'b0;
         rel_idx_q <= '0;
         rstn_q    <= '0;
         done_q    <= 1'b0;
         cause_q   <= '0;
      end else begin
         armed_q   <= armed_d;
         rel_idx_q <= rel_idx_d;
         rstn_q    <= rstn_d;
         done_q    <= done_d;
         cause_q   <= cause_d;
      end
   end
   assign rstn  = rstn_q;
   assign armed = armed_q;
   assign done  = done_q;
   assign cause = cause_q;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: scoreboard bench; expectations are queued by cycle and checked by a monitor
module tb_rst_seq;
  typedef struct {
    int         which;
    int         cyc;
    logic [2:0] rstn;
    logic       armed;
    logic       done;
    logic [2:0] cause;
    string      name;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] usr_rst = '0;
  logic [2:0] rstn_m, cause_m, rstn_a, cause_a;
  logic       armed_m, done_m, armed_a, done_a;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  rst_seq #(.N_CH(3), .STRETCH(4), .ARM_REQUIRED(1'b1)) dut (
    .clk(clk), .rst(rst), .usr_rst(usr_rst),
    .rstn(rstn_m), .armed(armed_m), .done(done_m), .cause(cause_m)
  );
  rst_seq #(.N_CH(3), .STRETCH(4), .ARM_REQUIRED(1'b0)) dut_a (
    .clk(clk), .rst(rst), .usr_rst(3'b000),
    .rstn(rstn_a), .armed(armed_a), .done(done_a), .cause(cause_a)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic expect_at(input int which, input int c, input logic [2:0] r, input logic a,
                           input logic d, input logic [2:0] ca, input string nm);
    exp_t e;
    e.which = which; e.cyc = c; e.rstn = r; e.armed = a; e.done = d; e.cause = ca; e.name = nm;
    sb.push_back(e);
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [2:0] r, ca;
        logic a, d;
        r  = sb[i].which == 0 ? rstn_m  : rstn_a;
        a  = sb[i].which == 0 ? armed_m : armed_a;
        d  = sb[i].which == 0 ? done_m  : done_a;
        ca = sb[i].which == 0 ? cause_m : cause_a;
        n_tests++;
        if (sb[i].cyc < cyc || r !== sb[i].rstn || a !== sb[i].armed || d !== sb[i].done ||
            ca !== sb[i].cause) begin
          n_fail++;
          $display("FAIL %s dut%0d cyc=%0d (want cyc %0d): rstn/armed/done/cause got %b/%b/%b/%b exp %b/%b/%b/%b",
                   sb[i].name, sb[i].which, cyc, sb[i].cyc, r, a, d, ca,
                   sb[i].rstn, sb[i].armed, sb[i].done, sb[i].cause);
        end
        sb.delete(i);
      end
    end
  end
  initial begin
    for (int c = 1; c <= 22; c++) expect_at(0, c, 3'b000, 0, 0, 3'b000, "idle");
    expect_at(1, 3, 3'b000, 1, 0, 3'b000, "auto_arm");
    expect_at(1, 7, 3'b001, 1, 0, 3'b000, "auto_r0");
    expect_at(1, 11, 3'b011, 1, 0, 3'b000, "auto_r1");
    expect_at(1, 14, 3'b011, 1, 0, 3'b000, "auto_pre");
    expect_at(1, 15, 3'b111, 1, 1, 3'b000, "auto_done");
    expect_at(0, 23, 3'b000, 1, 0, 3'b001, "arm_E");
    expect_at(0, 26, 3'b000, 1, 0, 3'b001, "arm_hold0");
    expect_at(0, 27, 3'b001, 1, 0, 3'b001, "arm_r0");
    expect_at(0, 30, 3'b001, 1, 0, 3'b001, "arm_hold1");
    expect_at(0, 31, 3'b011, 1, 0, 3'b001, "arm_r1");
    expect_at(0, 34, 3'b011, 1, 0, 3'b001, "arm_hold2");
    expect_at(0, 35, 3'b111, 1, 1, 3'b001, "arm_done");
    expect_at(0, 37, 3'b111, 1, 1, 3'b001, "done_cause");
    expect_at(0, 38, 3'b001, 1, 0, 3'b010, "pulse_F");
    expect_at(0, 41, 3'b001, 1, 0, 3'b010, "pulse_hold");
    expect_at(0, 42, 3'b011, 1, 0, 3'b010, "pulse_r1");
    expect_at(0, 45, 3'b011, 1, 0, 3'b010, "pulse_pre");
    expect_at(0, 46, 3'b111, 1, 1, 3'b010, "pulse_done");
    for (int c = 49; c <= 61; c++) expect_at(0, c, 3'b001, 1, 0, 3'b010, "hold");
    expect_at(0, 62, 3'b011, 1, 0, 3'b010, "hold_r1");
    expect_at(0, 65, 3'b011, 1, 0, 3'b010, "hold_pre");
    expect_at(0, 66, 3'b111, 1, 1, 3'b010, "hold_done");
    expect_at(0, 69, 3'b000, 1, 0, 3'b001, "mid_start");
    expect_at(0, 73, 3'b001, 1, 0, 3'b001, "mid_r0");
    expect_at(0, 75, 3'b001, 1, 0, 3'b101, "mid_hi_req");
    expect_at(0, 77, 3'b001, 1, 0, 3'b101, "mid_restart");
    expect_at(0, 78, 3'b001, 1, 0, 3'b101, "mid_pre");
    expect_at(0, 79, 3'b011, 1, 0, 3'b101, "mid_r1");
    expect_at(0, 80, 3'b011, 1, 0, 3'b101, "mid_hold");
    for (int c = 81; c <= 91; c++) expect_at(0, c, 3'b000, 0, 0, 3'b000, "rst_mid");
    expect_at(1, 81, 3'b000, 0, 0, 3'b000, "auto_rst");
    expect_at(1, 82, 3'b000, 1, 0, 3'b000, "auto_rearm");
    expect_at(1, 93, 3'b011, 1, 0, 3'b000, "auto_pre2");
    expect_at(1, 94, 3'b111, 1, 1, 3'b000, "auto_done2");
    expect_at(0, 92, 3'b000, 1, 0, 3'b100, "rearm");
    expect_at(0, 96, 3'b001, 1, 0, 3'b100, "rearm_r0");
    expect_at(0, 100, 3'b011, 1, 0, 3'b100, "rearm_r1");
    expect_at(0, 104, 3'b111, 1, 1, 3'b100, "rearm_done");
    wait_cyc(2);  rst = 1'b0;
    wait_cyc(22); usr_rst = 3'b001;
    wait_cyc(23); usr_rst = 3'b000;
    wait_cyc(37); usr_rst = 3'b010;
    wait_cyc(38); usr_rst = 3'b000;
    wait_cyc(48); usr_rst = 3'b010;
    wait_cyc(58); usr_rst = 3'b000;
    wait_cyc(68); usr_rst = 3'b001;
    wait_cyc(69); usr_rst = 3'b000;
    wait_cyc(74); usr_rst = 3'b100;
    wait_cyc(75); usr_rst = 3'b000;
    wait_cyc(80); rst = 1'b1;
    wait_cyc(81); rst = 1'b0;
    wait_cyc(91); usr_rst = 3'b100;
    wait_cyc(92); usr_rst = 3'b000;
    wait_cyc(110);
    n_tests += 6;
    if (rstn_m !== 3'b111) begin n_fail++; $display("FAIL end rstn_m %b", rstn_m); end
    if (armed_m !== 1'b1) begin n_fail++; $display("FAIL end armed_m %b", armed_m); end
    if (done_m !== 1'b1) begin n_fail++; $display("FAIL end done_m %b", done_m); end
    if (cause_m !== 3'b100) begin n_fail++; $display("FAIL end cause_m %b", cause_m); end
    if (rstn_a !== 3'b111) begin n_fail++; $display("FAIL end rstn_a %b", rstn_a); end
    if (done_a !== 1'b1 || cause_a !== 3'b000) begin n_fail++; $display("FAIL end done_a/cause_a %b/%b", done_a, cause_a); end
    while (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s never checked (cyc %0d)", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
